// File: rtl/debug_source_sched.sv
// Frame-synchronous scheduler sharing the 64-bit debug overlay word between NSRC producers.
// Optional build macro DEBUG_SCHED_FREEZE_EN adds i_freeze, which suppresses frame ticks in IDLE/HOLD.
module debug_source_sched #(
    parameter int unsigned NSRC         = 4,
    parameter int unsigned DWELL_FRAMES = 30,
    parameter int unsigned VBL_LINE     = 240,
    localparam int unsigned SW          = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [11:0]          i_v,
    input  logic [NSRC-1:0]      i_src_req,
    input  logic [64*NSRC-1:0]   i_src_data,
    input  logic                 i_manual_en,
`ifdef DEBUG_SCHED_FREEZE_EN
    input  logic                 i_freeze,
`endif
    input  logic [SW-1:0]        i_manual_sel,
    output logic [NSRC-1:0]      o_src_ack,
    output logic [63:0]          o_debug,
    output logic [SW-1:0]        o_sel,
    output logic                 o_valid
);

    localparam int unsigned DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state_q, state_nxt;
    logic [11:0]     v_prev_q;
    logic            tick_q;
    logic [DW-1:0]   dwell_q, dwell_nxt;
    logic [SW-1:0]   sel_nxt;
    logic            capture_c;
    logic            idle_c;
    logic            freeze_c;
    logic            tick_c;
    logic [SW-1:0]   man_sel_c;
    logic            low_found_c;
    logic [SW-1:0]   low_sel_c;
    logic            rr_found_c;
    logic [SW-1:0]   rr_sel_c;
    int unsigned     rr_idx;
    logic [63:0]     src_word [NSRC];

`ifdef DEBUG_SCHED_FREEZE_EN
    assign freeze_c = i_freeze;
`else
    assign freeze_c = 1'b0;
`endif

    assign tick_c = tick_q & ~freeze_c;

    for (genvar g = 0; g < NSRC; g++) begin : g_word
        assign src_word[g] = i_src_data[64*g +: 64];
    end

    // Out-of-range manual selections map to the last source
    assign man_sel_c = (32'(i_manual_sel) > NSRC - 1) ? SW'(NSRC - 1) : i_manual_sel;

    // Lowest-index requester, and round-robin search starting after the current source
    always_comb begin
        low_found_c = 1'b0;
        low_sel_c   = '0;
        rr_found_c  = 1'b0;
        rr_sel_c    = o_sel;
        rr_idx      = 0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (i_src_req[SW'(k)] && !low_found_c) begin
                low_found_c = 1'b1;
                low_sel_c   = SW'(k);
            end
        end
        for (int unsigned k = 1; k <= NSRC; k++) begin
            rr_idx = 32'(o_sel) + k;
            if (rr_idx >= NSRC) rr_idx = rr_idx - NSRC;
            if (i_src_req[SW'(rr_idx)] && !rr_found_c) begin
                rr_found_c = 1'b1;
                rr_sel_c   = SW'(rr_idx);
            end
        end
    end

    // Next-state logic; capture_c marks the edge that loads the output registers
    always_comb begin
        state_nxt = state_q;
        sel_nxt   = o_sel;
        dwell_nxt = dwell_q;
        capture_c = 1'b0;
        idle_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    if (i_manual_en) begin
                        sel_nxt   = man_sel_c;
                        dwell_nxt = DW'(DWELL_FRAMES - 1);
                        capture_c = 1'b1;
                        state_nxt = CAPTURE;
                    end else if (low_found_c) begin
                        sel_nxt   = low_sel_c;
                        dwell_nxt = DW'(DWELL_FRAMES - 1);
                        capture_c = 1'b1;
                        state_nxt = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (tick_c) begin
                    if (i_manual_en) begin
                        sel_nxt = man_sel_c;
                        if (man_sel_c != o_sel) dwell_nxt = DW'(DWELL_FRAMES - 1);
                        capture_c = 1'b1;
                        state_nxt = CAPTURE;
                    end else if (!i_src_req[o_sel] || (dwell_q == '0)) begin
                        if (rr_found_c) begin
                            sel_nxt   = rr_sel_c;
                            dwell_nxt = DW'(DWELL_FRAMES - 1);
                            capture_c = 1'b1;
                            state_nxt = CAPTURE;
                        end else begin
                            idle_c    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        dwell_nxt = dwell_q - DW'(1);
                        capture_c = 1'b1;
                        state_nxt = CAPTURE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, frame tick and registered outputs
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            v_prev_q  <= '0;
            tick_q    <= 1'b0;
            dwell_q   <= '0;
            o_src_ack <= '0;
            o_debug   <= '0;
            o_sel     <= '0;
            o_valid   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            v_prev_q  <= i_v;
            tick_q    <= (i_v == 12'(VBL_LINE)) && (v_prev_q != 12'(VBL_LINE));
            dwell_q   <= dwell_nxt;
            o_src_ack <= '0;
            if (capture_c) begin
                o_debug <= src_word[sel_nxt];
                o_sel   <= sel_nxt;
                o_valid <= 1'b1;
                if (i_src_req[sel_nxt]) o_src_ack <= NSRC'(1) << sel_nxt;
            end
            if (idle_c) o_valid <= 1'b0;
        end
    end

endmodule
